regfile_wr_ctrl: RTL and testbench



---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_wr_ctrl_wr_arb2.sv | 38 +++
 rtl/regfile_wr_ctrl.sv | 113 +++++++++++
 tb/tb_regfile_wr_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and encodings for the register file write-port controller
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  typedef enum logic {
    REQ_CORE = 1'b0,
    REQ_AUX  = 1'b1
  } req_id_t;

endpackage

// File: rtl/regfile_wr_ctrl_wr_arb2.sv
// rtl/regfile_wr_ctrl_wr_arb2.sv - two-input write grant; fixed core priority by default
// REGFILE_WR_CTRL_RR_EN selects round-robin with a priority flop.
module wr_arb2
  import regfile_pkg::*;
(
`ifdef REGFILE_WR_CTRL_RR_EN
  input  logic clk,
  input  logic reset,
  input  logic a_valid,
`endif
  input  logic en,
  input  logic c_valid,
  output logic c_gnt,
  output logic a_gnt
);

`ifdef REGFILE_WR_CTRL_RR_EN
  // prio names the requester that wins the next contested cycle
  req_id_t prio;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio <= REQ_CORE;
    end else if (c_valid && c_gnt) begin
      prio <= REQ_AUX;
    end else if (a_valid && a_gnt) begin
      prio <= REQ_CORE;
    end
  end

  assign c_gnt = en && (!a_valid || (prio == REQ_CORE));
  assign a_gnt = en && (!c_valid || (prio == REQ_AUX));
`else
  assign c_gnt = en;
  assign a_gnt = en && !c_valid;
`endif

endmodule

// File: rtl/regfile_wr_ctrl.sv
// rtl/regfile_wr_ctrl.sv - register file write-port owner: x1..x31 clear sequence, then core/aux writeback
// REGFILE_WR_CTRL_RR_EN selects round-robin arbitration instead of fixed core priority.
module regfile_wr_ctrl #(
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  input  logic              c_valid,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_data,
  output logic              c_ready,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  output logic              rf_en,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              busy
);
  import regfile_pkg::*;

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] idx, idx_nx;
  logic              rf_en_nx, busy_nx;
  logic [ADDR_W-1:0] rf_addr_nx;
  logic [DATA_W-1:0] rf_data_nx;
  logic              arb_en, c_gnt, a_gnt;

  // clr_req suppresses both grants so the cycle that starts a clear writes nothing
  assign arb_en = (state == RUN) && !clr_req;

  wr_arb2 u_arb (
`ifdef REGFILE_WR_CTRL_RR_EN
    .clk     (clk),
    .reset   (reset),
    .a_valid (a_valid),
`endif
    .en      (arb_en),
    .c_valid (c_valid),
    .c_gnt   (c_gnt),
    .a_gnt   (a_gnt)
  );

  assign c_ready = c_gnt;
  assign a_ready = a_gnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= CLEAR;
      idx     <= FIRST_IDX;
      rf_en   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
      busy    <= 1'b1;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      rf_en   <= rf_en_nx;
      rf_addr <= rf_addr_nx;
      rf_data <= rf_data_nx;
      busy    <= busy_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    rf_en_nx   = 1'b0;
    rf_addr_nx = rf_addr;
    rf_data_nx = rf_data;
    busy_nx    = busy;
    case (state)
      CLEAR: begin
        rf_en_nx   = 1'b1;
        rf_addr_nx = idx;
        rf_data_nx = '0;
        idx_nx     = idx + FIRST_IDX;
        if (idx == LAST_IDX) begin
          state_nx = RUN;
          busy_nx  = 1'b0;
        end
      end
      RUN: begin
        if (clr_req) begin
          state_nx = CLEAR;
          idx_nx   = FIRST_IDX;
          busy_nx  = 1'b1;
        end else if (c_valid && c_gnt) begin
          // x0 is hardwired zero: accept the transfer but drop the write
          if (c_addr != '0) begin
            rf_en_nx   = 1'b1;
            rf_addr_nx = c_addr;
            rf_data_nx = c_data;
          end
        end else if (a_valid && a_gnt) begin
          if (a_addr != '0) begin
            rf_en_nx   = 1'b1;
            rf_addr_nx = a_addr;
            rf_data_nx = a_data;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// tb/tb_regfile_wr_ctrl.sv - scoreboard bench for regfile_wr_ctrl (honours REGFILE_WR_CTRL_RR_EN)
`timescale 1ns/1ps
module tb_regfile_wr_ctrl;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clr_req = 1'b0;
  logic          c_valid = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [DW-1:0] c_data = '0;
  logic          a_valid = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_data = '0;
  logic          c_ready, a_ready, rf_en, busy;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;

  always #5 clk = ~clk;

  regfile_wr_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .clr_req (clr_req),
    .c_valid (c_valid),
    .c_addr  (c_addr),
    .c_data  (c_data),
    .c_ready (c_ready),
    .a_valid (a_valid),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .a_ready (a_ready),
    .rf_en   (rf_en),
    .rf_addr (rf_addr),
    .rf_data (rf_data),
    .busy    (busy)
  );

  typedef struct {
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          busy;
  } exp_t;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  bit            chk_en = 1'b0;
  bit            m_run;
  logic [AW-1:0] m_idx;
  bit            m_prio;
  logic [3:0]    grants;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_idx  = AW'(1);
    m_prio = 1'b0;
  endtask

  // called at a falling edge with inputs set; predicts readies and the next rf_* state
  task automatic step();
    exp_t e;
    bit   cr, ar;
    #1;
    if (!m_run || clr_req) begin
      cr = 1'b0;
      ar = 1'b0;
    end else begin
`ifdef REGFILE_WR_CTRL_RR_EN
      cr = !a_valid || !m_prio;
      ar = !c_valid || m_prio;
`else
      cr = 1'b1;
      ar = !c_valid;
`endif
    end
    check_eq("c_ready", 64'(c_ready), 64'(cr));
    check_eq("a_ready", 64'(a_ready), 64'(ar));
    e.en   = 1'b0;
    e.addr = '0;
    e.data = '0;
    if (!m_run) begin
      e.en   = 1'b1;
      e.addr = m_idx;
      if (m_idx == AW'(31)) m_run = 1'b1;
      m_idx++;
    end else if (clr_req) begin
      m_run = 1'b0;
      m_idx = AW'(1);
    end else if (c_valid && cr) begin
      e.en   = (c_addr != '0);
      e.addr = c_addr;
      e.data = c_data;
      m_prio = 1'b1;
    end else if (a_valid && ar) begin
      e.en   = (a_addr != '0);
      e.addr = a_addr;
      e.data = a_data;
      m_prio = 1'b0;
    end
    e.busy = !m_run;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (chk_en) begin
      check_eq("sb_depth", 64'(exp_q.size()), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("rf_en", 64'(rf_en), 64'(e.en));
        check_eq("busy", 64'(busy), 64'(e.busy));
        if (e.en) begin
          check_eq("rf_addr", 64'(rf_addr), 64'(e.addr));
          check_eq("rf_data", 64'(rf_data), 64'(e.data));
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rf_en", 64'(rf_en), 64'd0);
    check_eq("rst_rf_addr", 64'(rf_addr), 64'd0);
    check_eq("rst_rf_data", 64'(rf_data), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd1);
    reset  = 1'b1;
    chk_en = 1'b1;

    repeat (31) step();
    check_eq("clr_done_busy", 64'(busy), 64'd0);
    check_eq("clr_last_addr", 64'(rf_addr), 64'd31);
    step();

    c_valid = 1'b1; c_addr = AW'(5); c_data = 32'hDEADBEEF;
    step();
    check_eq("core_wr_addr", 64'(rf_addr), 64'd5);
    check_eq("core_wr_data", 64'(rf_data), 64'hDEADBEEF);
    c_valid = 1'b0;

    a_valid = 1'b1; a_addr = '0; a_data = 32'h1234;
    step();
    check_eq("aux_x0_drop", 64'(rf_en), 64'd0);
    a_valid = 1'b0;

    c_valid = 1'b1; c_addr = AW'(3); c_data = 32'h3333;
    a_valid = 1'b1; a_addr = AW'(7); a_data = 32'h7777;
    for (int i = 0; i < 4; i++) begin
      #1;
      grants[i] = a_ready;
      step();
    end
`ifdef REGFILE_WR_CTRL_RR_EN
    check_eq("contest_grants", 64'(grants), 64'b1010);
`else
    check_eq("contest_grants", 64'(grants), 64'b0000);
`endif
    c_valid = 1'b0;
    step();
    a_valid = 1'b0;
    step();

    c_valid = 1'b1; c_addr = AW'(9); c_data = 32'h9999;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    check_eq("clr_busy", 64'(busy), 64'd1);
    repeat (9) step();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (20) step();
    check_eq("clr_busy_30", 64'(busy), 64'd1);
    step();
    check_eq("clr_busy_31", 64'(busy), 64'd0);
    step();
    c_valid = 1'b0;
    step();

    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (11) step();
    c_valid = 1'b1; c_addr = AW'(4); c_data = 32'h4444;
    chk_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_rf_en", 64'(rf_en), 64'd0);
    check_eq("arst_rf_addr", 64'(rf_addr), 64'd0);
    check_eq("arst_rf_data", 64'(rf_data), 64'd0);
    check_eq("arst_busy", 64'(busy), 64'd1);
    check_eq("arst_c_ready", 64'(c_ready), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    exp_q.delete();
    chk_en = 1'b1;
    step();
    check_eq("restart_addr", 64'(rf_addr), 64'd1);
    repeat (30) step();
    step();
    c_valid = 1'b0;
    step();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
